midi_voice_alloc: RTL and testbench
===================================

// Module: midi_voice_alloc
// PURPOSE
// - Note-event initiator feeding the synth engine's note interface.
// - Parses a MIDI byte stream (running status) for one channel and allocates notes to VOICES voices.
// - Drives keys_on/note_on/cur_key_adr/cur_key_val/cur_vel_on/cur_vel_off.
// - Holds each event until the engine's xxxx_zero sync point has sampled it.
// PARAMETERS
// - VOICES   32  number of voices
// - V_WIDTH   5  clog2(VOICES), voice index width
// PORTS
// - AUDIO_CLK    in   1        sole clock
// - reset_reg    in   1        synchronous, active-high reset
// - byteready    in   1        1-cycle strobe: midibyte valid
// - midibyte     in   8        received MIDI byte
// - midi_ch      in   4        channel to accept (0..15)
// - xxxx_zero    in   1        engine sync strobe (event capture point)
// - voice_free   in   VOICES   1 = voice envelope finished, voice idle
// - keys_on      out  VOICES   1 = voice holds a pressed key
// - note_on      out  1        1 = current event is note-on, 0 = note-off
// - cur_key_adr  out  V_WIDTH  voice index of current event
// - cur_key_val  out  8        key number (0..127) of current event
// - cur_vel_on   out  8        note-on velocity (1..127)
// - cur_vel_off  out  8        note-off velocity
// - busy         out  1        allocator FSM not IDLE
// - overflow     out  1        1-cycle pulse: event dropped
// BEHAVIOUR
// - Reset: every output 0; key table 0; steal pointer 0; parser IDLE with no running status; pending buffer empty.
// - Parser (ST_IDLE/ST_D1/ST_D2), advances only on byteready:
//   - 0xF8-0xFF: ignored; state and running status untouched.
//   - 0xF0-0xF7: clear running status -> ST_IDLE.
//   - Other status: latch as running status -> ST_D1. Status counts only if channel == midi_ch and type is 0x8/0x9 (or 0xB with the macro).
//   - Data byte in ST_IDLE with valid running status -> treat as d1 -> ST_D2.
//   - Data byte with no running status: ignored.
//   - d2 received -> event complete -> ST_IDLE, running status kept.
//   - 0x9n with vel 0 == note-off, vel_off = 0x40.
// - Event queue: completed events go to a 1-deep pending buffer.
//   - If the buffer is full when a new event completes: drop the new event, pulse overflow.
// - Allocator FSM: A_IDLE -> A_SCAN -> A_ISSUE -> A_WAIT -> A_IDLE.
//   - A_IDLE: pops pending buffer; busy=1 from the next cycle.
//   - A_SCAN: scans idx 0..VOICES-1, one per cycle (exactly VOICES cycles).
//   - Note-on priority:
//     1. lowest idx with keys_on=1 and key==d1 (retrigger);
//     2. else lowest idx with keys_on=0 and voice_free=1;
//     3. else lowest idx with keys_on=0;
//     4. else steal voice at steal pointer, then pointer+1 mod VOICES.
//   - Note-off: lowest idx with keys_on=1 and key==d1. None found -> skip A_ISSUE/A_WAIT, back to A_IDLE, outputs unchanged.
//   - A_ISSUE (1 cycle):
//     - drive note_on, cur_key_adr, cur_key_val;
//     - note-on: cur_vel_on = d2, keys_on[idx] set, key table updated;
//     - note-off: cur_vel_off = d2, keys_on[idx] cleared.
//   - A_WAIT: outputs held stable until xxxx_zero seen in a cycle after A_ISSUE; A_IDLE next cycle.
// - Latency: note event -> outputs = 1 + VOICES + 1 cycles.
// - Simultaneous: pop and a new event arrival in the same cycle both succeed. Reset mid-scan/wait: immediate return to reset values.
// CONFIGURATION
// - ALL_NOTES_OFF_EN defined: 0xBn 0x7B xx on midi_ch clears all keys_on and the key table in one A_ISSUE-equivalent cycle.
//   - note_on=0, cur_key_adr unchanged, then A_WAIT as normal.
// - ALL_NOTES_OFF_EN undefined: 0xBn messages are parsed (running status honoured) and discarded.
// TESTING
// - ch0, all free: 90 3C 64 -> after 34 cycles keys_on=0x1, note_on=1, adr=0, key=0x3C, vel_on=0x64; held until xxxx_zero.
// - Running status: 90 3C 64 40 50 3C 00 -> voice0 on, voice1 on (key 0x40), then voice0 off with vel_off=0x40.
// - FE injected between 90 and 3C -> identical result to the no-FE case; F0 before data -> data ignored.
// - 33 distinct note-ons with xxxx_zero each 40 cycles -> 33rd steals voice0 (adr=0); next steal adr=1.
// - Three events back-to-back while busy -> first and second served, third dropped with a 1-cycle overflow pulse.
// - ALL_NOTES_OFF_EN: 5 voices on, then B0 7B 00 -> keys_on=0, note_on=0.

Source files
------------

// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc
// Single-channel MIDI byte parser with running status, plus a scanning voice
// allocator. The allocator presents one note event at a time on the engine's
// note interface and holds it until the engine's xxxx_zero sync point.
// Optional feature macro: ALL_NOTES_OFF_EN. When it is defined, controller
// 0x7B (all notes off) on the selected channel releases every voice.
`timescale 1ns/1ps
module midi_voice_alloc #(
   parameter int VOICES  = 32,
   parameter int V_WIDTH = 5
) (
   input  logic               AUDIO_CLK,
   input  logic               reset_reg,
   input  logic               byteready,
   input  logic [7:0]         midibyte,
   input  logic [3:0]         midi_ch,
   input  logic               xxxx_zero,
   input  logic [VOICES-1:0]  voice_free,
   output logic [VOICES-1:0]  keys_on,
   output logic               note_on,
   output logic [V_WIDTH-1:0] cur_key_adr,
   output logic [7:0]         cur_key_val,
   output logic [7:0]         cur_vel_on,
   output logic [7:0]         cur_vel_off,
   output logic               busy,
   output logic               overflow
);

   localparam logic [V_WIDTH-1:0] LAST_IDX = V_WIDTH'(VOICES - 1);

   typedef enum logic [1:0] { ST_IDLE, ST_D1, ST_D2 } p_state_t;
   typedef enum logic [1:0] { A_IDLE, A_SCAN, A_ISSUE, A_WAIT } a_state_t;

   // ---------------- parser ----------------
   p_state_t     p_state_q, p_state_d;
   logic         rs_valid_q, rs_valid_d;
   logic [7:0]   rs_status_q, rs_status_d;
   logic [6:0]   d1_q, d1_d;

   logic         evt_done;
   logic         evt_on;
   logic         evt_all;
   logic [6:0]   evt_vel;

   // ---------------- pending buffer ----------------
   logic         pend_valid_q, pend_valid_d;
   logic         pend_on_q, pend_on_d;
   logic         pend_all_q, pend_all_d;
   logic [6:0]   pend_key_q, pend_key_d;
   logic [6:0]   pend_vel_q, pend_vel_d;
   logic         overflow_q, overflow_d;
   logic         pop;

   // ---------------- allocator ----------------
   a_state_t     a_state_q, a_state_d;
   logic [V_WIDTH-1:0] scan_idx_q, scan_idx_d;
   logic         ev_on_q, ev_on_d;
   logic         ev_all_q, ev_all_d;
   logic [6:0]   ev_key_q, ev_key_d;
   logic [6:0]   ev_vel_q, ev_vel_d;
   logic         hit_f_q, hit_f_d;
   logic [V_WIDTH-1:0] hit_idx_q, hit_idx_d;
   logic         free_f_q, free_f_d;
   logic [V_WIDTH-1:0] free_idx_q, free_idx_d;
   logic         empty_f_q, empty_f_d;
   logic [V_WIDTH-1:0] empty_idx_q, empty_idx_d;
   logic [V_WIDTH-1:0] sel_idx_q, sel_idx_d;
   logic [V_WIDTH-1:0] steal_q, steal_d;

   logic [VOICES-1:0]  keys_on_q, keys_on_d;
   logic [6:0]         key_tab_q [VOICES];
   logic [6:0]         key_tab_d [VOICES];
   logic               note_on_q, note_on_d;
   logic [V_WIDTH-1:0] cur_key_adr_q, cur_key_adr_d;
   logic [6:0]         cur_key_val_q, cur_key_val_d;
   logic [6:0]         cur_vel_on_q, cur_vel_on_d;
   logic [6:0]         cur_vel_off_q, cur_vel_off_d;

   logic         scan_on;
   logic         scan_match;
   logic         scan_free;

   // Parser next state: status/data classification and event completion
   always_comb begin
      p_state_d   = p_state_q;
      rs_valid_d  = rs_valid_q;
      rs_status_d = rs_status_q;
      d1_d        = d1_q;
      evt_done    = 1'b0;
      evt_on      = 1'b0;
      evt_all     = 1'b0;
      evt_vel     = 7'd0;
      if (byteready) begin
         if (midibyte[7:3] == 5'b11111) begin
            // real-time bytes are transparent to the parser
         end else if (midibyte[7:4] == 4'hF) begin
            // system common / sysex cancels running status
            rs_valid_d = 1'b0;
            p_state_d  = ST_IDLE;
         end else if (midibyte[7]) begin
            rs_valid_d  = 1'b1;
            rs_status_d = midibyte;
            p_state_d   = ST_D1;
         end else begin
            case (p_state_q)
               ST_D1: begin
                  d1_d      = midibyte[6:0];
                  p_state_d = ST_D2;
               end
               ST_D2: begin
                  p_state_d = ST_IDLE;
                  if (rs_status_q[3:0] == midi_ch) begin
                     case (rs_status_q[7:4])
                        4'h9: begin
                           evt_done = 1'b1;
                           evt_on   = (midibyte[6:0] != 7'd0);
                           // zero-velocity note-on is a note-off with default release
                           evt_vel  = (midibyte[6:0] != 7'd0) ? midibyte[6:0] : 7'h40;
                        end
                        4'h8: begin
                           evt_done = 1'b1;
                           evt_vel  = midibyte[6:0];
                        end
`ifdef ALL_NOTES_OFF_EN
                        4'hB: begin
                           if (d1_q == 7'h7B) begin
                              evt_done = 1'b1;
                              evt_all  = 1'b1;
                           end
                        end
`endif
                        default: ;
                     endcase
                  end
               end
               default: begin
                  // running status: a data byte in idle starts a new message
                  if (rs_valid_q) begin
                     d1_d      = midibyte[6:0];
                     p_state_d = ST_D2;
                  end
               end
            endcase
         end
      end
   end

   // Parser registers
   always_ff @(posedge AUDIO_CLK) begin
      if (reset_reg) begin
         p_state_q   <= ST_IDLE;
         rs_valid_q  <= 1'b0;
         rs_status_q <= 8'd0;
         d1_q        <= 7'd0;
      end else begin
         p_state_q   <= p_state_d;
         rs_valid_q  <= rs_valid_d;
         rs_status_q <= rs_status_d;
         d1_q        <= d1_d;
      end
   end

   // Pending buffer: a new event is dropped only if the slot stays occupied
   always_comb begin
      pend_valid_d = pend_valid_q && !pop;
      pend_on_d    = pend_on_q;
      pend_all_d   = pend_all_q;
      pend_key_d   = pend_key_q;
      pend_vel_d   = pend_vel_q;
      overflow_d   = 1'b0;
      if (evt_done) begin
         if (pend_valid_q && !pop) begin
            overflow_d = 1'b1;
         end else begin
            pend_valid_d = 1'b1;
            pend_on_d    = evt_on;
            pend_all_d   = evt_all;
            pend_key_d   = d1_q;
            pend_vel_d   = evt_vel;
         end
      end
   end

   // Pending buffer registers
   always_ff @(posedge AUDIO_CLK) begin
      if (reset_reg) begin
         pend_valid_q <= 1'b0;
         pend_on_q    <= 1'b0;
         pend_all_q   <= 1'b0;
         pend_key_q   <= 7'd0;
         pend_vel_q   <= 7'd0;
         overflow_q   <= 1'b0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_on_q    <= pend_on_d;
         pend_all_q   <= pend_all_d;
         pend_key_q   <= pend_key_d;
         pend_vel_q   <= pend_vel_d;
         overflow_q   <= overflow_d;
      end
   end

   assign scan_on    = keys_on_q[scan_idx_q];
   assign scan_match = scan_on && (key_tab_q[scan_idx_q] == ev_key_q);
   assign scan_free  = !scan_on && voice_free[scan_idx_q];

   // Allocator FSM: pop, linear scan for candidates, issue, hold until sync
   always_comb begin
      a_state_d     = a_state_q;
      scan_idx_d    = scan_idx_q;
      ev_on_d       = ev_on_q;
      ev_all_d      = ev_all_q;
      ev_key_d      = ev_key_q;
      ev_vel_d      = ev_vel_q;
      hit_f_d       = hit_f_q;
      hit_idx_d     = hit_idx_q;
      free_f_d      = free_f_q;
      free_idx_d    = free_idx_q;
      empty_f_d     = empty_f_q;
      empty_idx_d   = empty_idx_q;
      sel_idx_d     = sel_idx_q;
      steal_d       = steal_q;
      keys_on_d     = keys_on_q;
      key_tab_d     = key_tab_q;
      note_on_d     = note_on_q;
      cur_key_adr_d = cur_key_adr_q;
      cur_key_val_d = cur_key_val_q;
      cur_vel_on_d  = cur_vel_on_q;
      cur_vel_off_d = cur_vel_off_q;
      pop           = 1'b0;
      case (a_state_q)
         A_IDLE: begin
            if (pend_valid_q) begin
               pop         = 1'b1;
               ev_on_d     = pend_on_q;
               ev_all_d    = pend_all_q;
               ev_key_d    = pend_key_q;
               ev_vel_d    = pend_vel_q;
               hit_f_d     = 1'b0;
               free_f_d    = 1'b0;
               empty_f_d   = 1'b0;
               scan_idx_d  = '0;
               a_state_d   = A_SCAN;
            end
         end
         A_SCAN: begin
            // keep only the lowest index for each candidate class
            if (!hit_f_q && scan_match) begin
               hit_f_d   = 1'b1;
               hit_idx_d = scan_idx_q;
            end
            if (!free_f_q && scan_free) begin
               free_f_d   = 1'b1;
               free_idx_d = scan_idx_q;
            end
            if (!empty_f_q && !scan_on) begin
               empty_f_d   = 1'b1;
               empty_idx_d = scan_idx_q;
            end
            scan_idx_d = scan_idx_q + 1'b1;
            if (scan_idx_q == LAST_IDX) begin
               if (ev_all_q) begin
                  a_state_d = A_ISSUE;
               end else if (ev_on_q) begin
                  a_state_d = A_ISSUE;
                  if (hit_f_d) begin
                     sel_idx_d = hit_idx_d;
                  end else if (free_f_d) begin
                     sel_idx_d = free_idx_d;
                  end else if (empty_f_d) begin
                     sel_idx_d = empty_idx_d;
                  end else begin
                     sel_idx_d = steal_q;
                     steal_d   = (steal_q == LAST_IDX) ? '0 : steal_q + 1'b1;
                  end
               end else if (hit_f_d) begin
                  sel_idx_d = hit_idx_d;
                  a_state_d = A_ISSUE;
               end else begin
                  // note-off for a key nobody holds: nothing to present
                  a_state_d = A_IDLE;
               end
            end
         end
         A_ISSUE: begin
            a_state_d = A_WAIT;
            if (ev_all_q) begin
               note_on_d = 1'b0;
               keys_on_d = '0;
               for (int i = 0; i < VOICES; i++) begin
                  key_tab_d[i] = 7'd0;
               end
            end else if (ev_on_q) begin
               note_on_d            = 1'b1;
               cur_key_adr_d        = sel_idx_q;
               cur_key_val_d        = ev_key_q;
               cur_vel_on_d         = ev_vel_q;
               keys_on_d[sel_idx_q] = 1'b1;
               key_tab_d[sel_idx_q] = ev_key_q;
            end else begin
               note_on_d            = 1'b0;
               cur_key_adr_d        = sel_idx_q;
               cur_key_val_d        = ev_key_q;
               cur_vel_off_d        = ev_vel_q;
               keys_on_d[sel_idx_q] = 1'b0;
            end
         end
         default: begin
            if (xxxx_zero) begin
               a_state_d = A_IDLE;
            end
         end
      endcase
   end

   // Allocator and output registers
   always_ff @(posedge AUDIO_CLK) begin
      if (reset_reg) begin
         a_state_q     <= A_IDLE;
         scan_idx_q    <= '0;
         ev_on_q       <= 1'b0;
         ev_all_q      <= 1'b0;
         ev_key_q      <= 7'd0;
         ev_vel_q      <= 7'd0;
         hit_f_q       <= 1'b0;
         hit_idx_q     <= '0;
         free_f_q      <= 1'b0;
         free_idx_q    <= '0;
         empty_f_q     <= 1'b0;
         empty_idx_q   <= '0;
         sel_idx_q     <= '0;
         steal_q       <= '0;
         keys_on_q     <= '0;
         note_on_q     <= 1'b0;
         cur_key_adr_q <= '0;
         cur_key_val_q <= 7'd0;
         cur_vel_on_q  <= 7'd0;
         cur_vel_off_q <= 7'd0;
         for (int i = 0; i < VOICES; i++) begin
            key_tab_q[i] <= 7'd0;
         end
      end else begin
         a_state_q     <= a_state_d;
         scan_idx_q    <= scan_idx_d;
         ev_on_q       <= ev_on_d;
         ev_all_q      <= ev_all_d;
         ev_key_q      <= ev_key_d;
         ev_vel_q      <= ev_vel_d;
         hit_f_q       <= hit_f_d;
         hit_idx_q     <= hit_idx_d;
         free_f_q      <= free_f_d;
         free_idx_q    <= free_idx_d;
         empty_f_q     <= empty_f_d;
         empty_idx_q   <= empty_idx_d;
         sel_idx_q     <= sel_idx_d;
         steal_q       <= steal_d;
         keys_on_q     <= keys_on_d;
         note_on_q     <= note_on_d;
         cur_key_adr_q <= cur_key_adr_d;
         cur_key_val_q <= cur_key_val_d;
         cur_vel_on_q  <= cur_vel_on_d;
         cur_vel_off_q <= cur_vel_off_d;
         for (int i = 0; i < VOICES; i++) begin
            key_tab_q[i] <= key_tab_d[i];
         end
      end
   end

   assign keys_on     = keys_on_q;
   assign note_on     = note_on_q;
   assign cur_key_adr = cur_key_adr_q;
   assign cur_key_val = {1'b0, cur_key_val_q};
   assign cur_vel_on  = {1'b0, cur_vel_on_q};
   assign cur_vel_off = {1'b0, cur_vel_off_q};
   assign busy        = (a_state_q != A_IDLE);
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Testbench for midi_voice_alloc: directed MIDI sequences plus randomized
// messages, checked by a scoreboard fed from a message-level reference model.
`timescale 1ns/1ps
module tb_midi_voice_alloc;
   localparam int VOICES    = 32;
   localparam int V_WIDTH   = 5;
   localparam int ISSUE_CNT = VOICES + 2;

   logic               clk = 1'b0;
   logic               reset_reg = 1'b1;
   logic               byteready = 1'b0;
   logic [7:0]         midibyte = 8'd0;
   logic [3:0]         midi_ch = 4'd0;
   logic               xxxx_zero = 1'b0;
   logic [VOICES-1:0]  voice_free = '1;
   logic [VOICES-1:0]  keys_on;
   logic               note_on;
   logic [V_WIDTH-1:0] cur_key_adr;
   logic [7:0]         cur_key_val;
   logic [7:0]         cur_vel_on;
   logic [7:0]         cur_vel_off;
   logic               busy;
   logic               overflow;

   always #5 clk = ~clk;

   midi_voice_alloc #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) dut (
      .AUDIO_CLK   (clk),
      .reset_reg   (reset_reg),
      .byteready   (byteready),
      .midibyte    (midibyte),
      .midi_ch     (midi_ch),
      .xxxx_zero   (xxxx_zero),
      .voice_free  (voice_free),
      .keys_on     (keys_on),
      .note_on     (note_on),
      .cur_key_adr (cur_key_adr),
      .cur_key_val (cur_key_val),
      .cur_vel_on  (cur_vel_on),
      .cur_vel_off (cur_vel_off),
      .busy        (busy),
      .overflow    (overflow)
   );

   typedef struct {
      bit                noop;
      bit                note_on;
      int                adr;
      int                key;
      int                vel_on;
      int                vel_off;
      logic [VOICES-1:0] keys;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // reference model state (message level)
   int m_rs;
   int m_need;
   int m_d1;
   bit m_keys [VOICES];
   int m_key  [VOICES];
   int m_steal;
   bit m_note_on;
   int m_adr, m_kv, m_von, m_voff;
   bit m_dropping = 1'b0;
   int ov_exp = 0;
   int ov_seen = 0;

   function automatic void check(string name, longint act, longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic void model_reset();
      m_rs = -1; m_need = 0; m_d1 = 0; m_steal = 0;
      m_note_on = 1'b0; m_adr = 0; m_kv = 0; m_von = 0; m_voff = 0;
      for (int i = 0; i < VOICES; i++) begin
         m_keys[i] = 1'b0;
         m_key[i]  = 0;
      end
   endfunction

   function automatic exp_t snap(bit noop);
      exp_t e;
      e.noop = noop; e.note_on = m_note_on; e.adr = m_adr; e.key = m_kv;
      e.vel_on = m_von; e.vel_off = m_voff;
      for (int i = 0; i < VOICES; i++) e.keys[i] = m_keys[i];
      return e;
   endfunction

   function automatic void alloc_on(int key, int vel);
      int v;
      v = -1;
      for (int i = 0; i < VOICES; i++) if (v < 0 && m_keys[i] && m_key[i] == key) v = i;
      for (int i = 0; i < VOICES; i++) if (v < 0 && !m_keys[i] && voice_free[i]) v = i;
      for (int i = 0; i < VOICES; i++) if (v < 0 && !m_keys[i]) v = i;
      if (v < 0) begin
         v = m_steal;
         m_steal = (m_steal + 1) % VOICES;
      end
      m_keys[v] = 1'b1; m_key[v] = key;
      m_note_on = 1'b1; m_adr = v; m_kv = key; m_von = vel;
      sb.push_back(snap(1'b0));
   endfunction

   function automatic void alloc_off(int key, int vel);
      int v;
      v = -1;
      for (int i = 0; i < VOICES; i++) if (v < 0 && m_keys[i] && m_key[i] == key) v = i;
      if (v < 0) begin
         sb.push_back(snap(1'b1));
      end else begin
         m_keys[v] = 1'b0;
         m_note_on = 1'b0; m_adr = v; m_kv = key; m_voff = vel;
         sb.push_back(snap(1'b0));
      end
   endfunction

   function automatic void all_off();
      for (int i = 0; i < VOICES; i++) begin
         m_keys[i] = 1'b0;
         m_key[i]  = 0;
      end
      m_note_on = 1'b0;
      sb.push_back(snap(1'b0));
   endfunction

   // returns 1 when the message reaches the allocator
   function automatic bit model_msg(int st, int d1, int d2);
      int ty;
      bit acc;
      ty = st >> 4;
      if ((st & 15) != int'(midi_ch)) return 1'b0;
      acc = (ty == 9 || ty == 8);
`ifdef ALL_NOTES_OFF_EN
      if (ty == 'hB && d1 == 'h7B) acc = 1'b1;
`endif
      if (!acc) return 1'b0;
      if (m_dropping) begin
         ov_exp++;
         return 1'b0;
      end
      if (ty == 9 && d2 != 0) alloc_on(d1, d2);
      else if (ty == 9) alloc_off(d1, 'h40);
      else if (ty == 8) alloc_off(d1, d2);
      else all_off();
      return 1'b1;
   endfunction

   function automatic bit model_byte(int b);
      if (b >= 'hF8) return 1'b0;
      if (b >= 'hF0) begin m_rs = -1; m_need = 0; return 1'b0; end
      if (b >= 'h80) begin m_rs = b; m_need = 1; return 1'b0; end
      if (m_need == 2) begin
         m_need = 0;
         return model_msg(m_rs, m_d1, b);
      end
      if (m_need == 1 || m_rs >= 0) begin
         m_d1 = b;
         m_need = 2;
      end
      return 1'b0;
   endfunction

   task automatic send_byte(input int b, output bit ev);
      @(posedge clk); #1;
      byteready = 1'b1;
      midibyte  = b[7:0];
      ev = model_byte(b);
      @(posedge clk); #1;
      byteready = 1'b0;
   endtask

   task automatic wait_alloc();
      int n;
      n = 0;
      while (!busy && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (!busy) begin
         failures++;
         $display("FAIL busy_rise actual=timeout required=busy within 20 cycles");
         return;
      end
      n = 0;
      while (busy && n < 3000) begin @(negedge clk); n++; end
      checks++;
      if (busy) begin
         failures++;
         $display("FAIL busy_fall actual=timeout required=idle within 3000 cycles");
      end
   endtask

   task automatic send_p(input int b);
      bit ev;
      send_byte(b, ev);
      if (ev) wait_alloc();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset_reg = 1'b1;
      sb.delete();
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset_reg = 1'b0;
      @(negedge clk);
      check("rst_keys_on", keys_on, 0);
      check("rst_note_on", note_on, 0);
      check("rst_adr", cur_key_adr, 0);
      check("rst_key_val", cur_key_val, 0);
      check("rst_vel_on", cur_vel_on, 0);
      check("rst_vel_off", cur_vel_off, 0);
      check("rst_busy", busy, 0);
      check("rst_overflow", overflow, 0);
   endtask

   // engine sync strobe, irregular
   initial begin
      forever begin
         @(posedge clk); #1;
         xxxx_zero = ($urandom_range(0, 4) == 0);
      end
   end

   // monitor: output presentation is the 34th busy cycle; a silent scan ends early
   initial begin
      int   cnt;
      bit   busy_prev;
      bit   ov_prev;
      exp_t e;
      exp_t last;
      cnt = 0; busy_prev = 1'b0; ov_prev = 1'b0;
      last = '{default: 0};
      forever begin
         @(negedge clk);
         if (reset_reg) begin
            cnt = 0; busy_prev = 1'b0; ov_prev = 1'b0;
         end else begin
            if (overflow) begin
               ov_seen++;
               check("overflow_pulse_width", ov_prev, 0);
            end
            ov_prev = overflow;
            if (busy) begin
               cnt++;
            end
            if ((busy && cnt == ISSUE_CNT) || (!busy && busy_prev && cnt < ISSUE_CNT)) begin
               if (sb.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL scoreboard_underflow actual=event required=none at %0t", $time);
               end else begin
                  e = sb.pop_front();
                  check("event_kind_noop", !busy, e.noop);
                  check("keys_on", keys_on, e.keys);
                  check("note_on", note_on, e.note_on);
                  check("cur_key_adr", cur_key_adr, e.adr);
                  check("cur_key_val", cur_key_val, e.key);
                  check("cur_vel_on", cur_vel_on, e.vel_on);
                  check("cur_vel_off", cur_vel_off, e.vel_off);
                  last = e;
                  $display("txn t=%0t noop=%0d note_on=%0d adr=%0d key=0x%0h von=0x%0h voff=0x%0h keys=0x%0h",
                           $time, e.noop, note_on, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off, keys_on);
               end
            end
            if (!busy && busy_prev && cnt >= ISSUE_CNT) begin
               check("hold_keys_on", keys_on, last.keys);
               check("hold_note_on", note_on, last.note_on);
               check("hold_adr", cur_key_adr, last.adr);
               check("hold_key_val", cur_key_val, last.key);
            end
            if (!busy) cnt = 0;
            busy_prev = busy;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ev;
      model_reset();
      do_reset();

      // basic note-on, running status, velocity-zero note-off
      send_p('h90); send_p('h3C); send_p('h64);
      send_p('h40); send_p('h50);
      send_p('h3C); send_p('h00);
      // real-time byte inside a message is transparent
      send_p('h90); send_p('hFE); send_p('h3C); send_p('h64);
      // system byte cancels running status: following data ignored
      send_p('h90); send_p('hF0); send_p('h3C); send_p('h64);
      // note-off for an unheld key
      send_p('h80); send_p('h11); send_p('h22);

      // reset in the middle of a scan
      send_byte('h90, ev); send_byte('h45, ev); send_byte('h30, ev);
      repeat (10) @(posedge clk);
      do_reset();

      // fill all voices, then steal twice
      for (int i = 0; i < VOICES + 1; i++) begin
         send_p('h90); send_p('h10 + i); send_p('h20);
      end
      @(negedge clk);
      check("steal_first_adr", cur_key_adr, 0);
      send_p('h90); send_p('h70); send_p('h21);
      @(negedge clk);
      check("steal_second_adr", cur_key_adr, 1);

      // three events back to back: third is dropped
      send_byte('h90, ev); send_byte('h05, ev); send_byte('h11, ev);
      send_byte('h06, ev); send_byte('h12, ev);
      m_dropping = 1'b1;
      send_byte('h07, ev); send_byte('h13, ev);
      m_dropping = 1'b0;
      wait_alloc();
      wait_alloc();

      // randomized messages
      for (int m = 0; m < 160; m++) begin
         int typ, ch, st, d1, d2;
         if (m % 20 == 0) midi_ch = 4'($urandom_range(0, 15));
         voice_free = $urandom();
         typ = $urandom_range(0, 9);
         if (typ == 9) begin
            send_p($urandom_range('hF0, 'hF7));
         end else begin
            ch = ($urandom_range(0, 9) < 8) ? int'(midi_ch) : $urandom_range(0, 15);
            st = (typ <= 5) ? 'h90 : (typ <= 7) ? 'h80 : 'hB0;
            st = st | ch;
            d1 = (typ == 8) ? (($urandom_range(0, 1) == 1) ? 'h7B : 'h07) : 'h30 + $urandom_range(0, 7);
            d2 = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 127);
            if ($urandom_range(0, 2) != 0) send_p(st);
            if ($urandom_range(0, 9) == 0) send_p($urandom_range('hF8, 'hFF));
            send_p(d1);
            if ($urandom_range(0, 9) == 0) send_p($urandom_range('hF8, 'hFF));
            send_p(d2);
         end
      end

`ifdef ALL_NOTES_OFF_EN
      midi_ch = 4'd0;
      for (int i = 0; i < 5; i++) begin
         send_p('h90); send_p('h50 + i); send_p('h40);
      end
      send_p('hB0); send_p('h7B); send_p('h00);
      @(negedge clk);
      check("all_off_keys_on", keys_on, 0);
      check("all_off_note_on", note_on, 0);
`endif

      repeat (5) @(negedge clk);
      check("overflow_count", ov_seen, ov_exp);
      check("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
